// File: rtl/hilo_md_sequencer.sv
// HI/LO register owner and issue/stall sequencer for the clocked multiplier and
// iterative divider of the single-cycle core.
module hilo_md_sequencer #(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] opnd_a,
    output logic [31:0] opnd_b,
    output logic        div_start,
    output logic        div_signed,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_by_zero,
    output logic        err_timeout
);

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam int unsigned CNT_MAX = (DIV_TIMEOUT > MUL_LAT) ? DIV_TIMEOUT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_INIT     = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_START,
        S_DIV_WAIT,
        S_WB
    } state_e;

    // Which result source the WB cycle commits into HI/LO.
    typedef enum logic [1:0] {
        WB_MUL,
        WB_DIV,
        WB_DZ
    } wb_src_e;

    state_e           state_q;
    wb_src_e          wb_src_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      opnd_a_q;
    logic [31:0]      opnd_b_q;
    logic             div_signed_q;
    logic             div_start_q;
    logic             div_by_zero_q;
    logic             err_timeout_q;

    logic accept;
    logic is_long;
    logic busy_state;

    assign accept     = (state_q == S_IDLE) && ena && op_valid && (op_code != OP_RSVD);
    assign is_long    = (op_code == OP_MULTU) || (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign busy_state = (state_q != S_IDLE) && (state_q != S_WB);

    // Reset overrides the whole stall term so the PC is never held during reset.
    assign stall = rst && (busy_state || (accept && is_long));

    assign opnd_a      = opnd_a_q;
    assign opnd_b      = opnd_b_q;
    assign div_signed  = div_signed_q;
    assign div_start   = div_start_q && ena;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign div_by_zero = div_by_zero_q;
    assign err_timeout = err_timeout_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        rd_data = '0;
        if (accept && (op_code == OP_MFHI)) begin
            rd_data = hi_q;
        end else if (accept && (op_code == OP_MFLO)) begin
            rd_data = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wb_src_q      <= WB_MUL;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            opnd_a_q      <= '0;
            opnd_b_q      <= '0;
            div_signed_q  <= 1'b0;
            div_start_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else if (ena) begin
            div_start_q   <= 1'b0;
            div_by_zero_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        opnd_a_q <= rs_data;
                        opnd_b_q <= rt_data;
                        case (op_code)
                            OP_MULTU: begin
                                cnt_q    <= MUL_INIT;
                                wb_src_q <= WB_MUL;
                                state_q  <= S_MUL_WAIT;
                            end
                            OP_DIV, OP_DIVU: begin
                                div_signed_q <= (op_code == OP_DIV);
                                if (rt_data == '0) begin
                                    wb_src_q      <= WB_DZ;
                                    div_by_zero_q <= 1'b1;
                                    state_q       <= S_WB;
                                end else begin
                                    wb_src_q    <= WB_DIV;
                                    div_start_q <= 1'b1;
                                    state_q     <= S_DIV_START;
                                end
                            end
                            OP_MTHI: hi_q <= rs_data;
                            OP_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end

                S_MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_WB;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_DIV_START: begin
                    cnt_q   <= '0;
                    state_q <= S_DIV_WAIT;
                end

                S_DIV_WAIT: begin
                    // cnt_q==0 marks the first wait cycle, where div_busy may
                    // not yet reflect the start pulse.
                    cnt_q <= cnt_q + CNT_W'(1);
                    if ((cnt_q != '0) && !div_busy) begin
                        state_q <= S_WB;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end

                S_WB: begin
                    case (wb_src_q)
                        WB_MUL: begin
                            hi_q <= mul_hi;
                            lo_q <= mul_lo;
                        end
                        WB_DIV: begin
                            hi_q <= div_r;
                            lo_q <= div_q;
                        end
                        default: begin
                            hi_q <= opnd_a_q;
                            lo_q <= '1;
                        end
                    endcase
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Self-checking bench for hilo_md_sequencer: behavioural multiplier/divider
// models around the DUT and a HI/LO scoreboard for the long operations.
module tb_hilo_md_sequencer;

    localparam int MUL_LAT     = 2;
    localparam int DIV_TIMEOUT = 64;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic        div_start;
    logic        div_signed;
    logic        div_busy = 1'b0;
    logic [31:0] div_q    = '0;
    logic [31:0] div_r    = '0;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;
    logic        err_timeout;

    logic [63:0] sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_start  = 0;
    int          n_dz     = 0;
    logic        last_signed = 1'b0;
    int          div_busy_len = 32;
    bit          div_stuck    = 1'b0;
    int          busy_cnt     = 0;

    hilo_md_sequencer #(
        .MUL_LAT    (MUL_LAT),
        .DIV_TIMEOUT(DIV_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .rd_data    (rd_data),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_busy   (div_busy),
        .div_q      (div_q),
        .div_r      (div_r),
        .mul_hi     (mul_hi),
        .mul_lo     (mul_lo),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .div_by_zero(div_by_zero),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product is stable as long as the latched operands are.
    logic [63:0] mul_prod;
    assign mul_prod = 64'(opnd_a) * 64'(opnd_b);
    assign mul_hi   = mul_prod[63:32];
    assign mul_lo   = mul_prod[31:0];

    // Divider model: busy for div_busy_len cycles after a start, or forever when stuck.
    always @(posedge clk) begin
        if (!rst) begin
            div_busy <= 1'b0;
            busy_cnt <= 0;
        end else if (div_start) begin
            div_busy <= 1'b1;
            busy_cnt <= div_busy_len;
            if (div_signed) begin
                div_q <= $signed(opnd_a) / $signed(opnd_b);
                div_r <= $signed(opnd_a) % $signed(opnd_b);
            end else begin
                div_q <= opnd_a / opnd_b;
                div_r <= opnd_a % opnd_b;
            end
        end else if (div_busy && !div_stuck) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) div_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst && div_start) begin
            n_start     = n_start + 1;
            last_signed = div_signed;
        end
        if (rst && div_by_zero) n_dz = n_dz + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Issues one long op for a single cycle, counts stall cycles (optionally
    // with a 5-cycle ena gap starting at stall cycle 'gap'), then checks HI/LO
    // one cycle after stall releases against the scoreboard entry.
    task automatic run_long(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int exp_stall, input int gap);
        int          n;
        logic [63:0] exp;
        sb_q.push_back({exp_hi, exp_lo});
        @(posedge clk); #1;
        ena = 1'b1; op_valid = 1'b1; op_code = op; rs_data = a; rt_data = b;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(posedge clk); #1;
            op_valid = 1'b0;
            ena = !(gap >= 0 && n >= gap && n < gap + 5);
            @(negedge clk);
        end
        ena = 1'b1;
        check({tag, "_stall_cycles"}, n, exp_stall);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        exp = sb_q.pop_front();
        check({tag, "_hi"}, hi_out, exp[63:32]);
        check({tag, "_lo"}, lo_out, exp[31:0]);
    endtask

    initial begin
        int n0_start;
        int n;
        bit bad;

        rst = 1'b0; ena = 1'b1; op_valid = 1'b1; op_code = OP_MULTU;
        rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall_forced", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_dz", div_by_zero, 1'b0);
        check("rst_start", div_start, 1'b0);
        check("rst_opnd_a", opnd_a, 32'h0);
        check("rst_stall", stall, 1'b0);

        @(posedge clk); #1;
        op_valid = 1'b1; op_code = OP_RSVD; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rsvd_stall", stall, 1'b0);
        check("rsvd_rd", rd_data, 32'h0);

        run_long("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 3, -1);
        check("multu_no_start", n_start, 0);

        // Busy 32 cycles: accept + DIV_START + 32 busy cycles + the cycle that sees busy low.
        div_busy_len = 32;
        run_long("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, -1);
        check("div_start_pulses", n_start, 1);
        check("div_signed", last_signed, 1'b1);

        n0_start = n_start;
        run_long("divu_dz", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, -1);
        check("divu_dz_no_start", n_start, n0_start);
        check("divu_dz_pulses", n_dz, 1);

        @(posedge clk); #1;
        op_valid = 1'b1; op_code = OP_MTHI; rs_data = 32'h1234;
        @(negedge clk);
        check("mthi_stall", stall, 1'b0);
        @(posedge clk); #1;
        op_code = OP_MFHI; rs_data = 32'h0;
        @(negedge clk);
        check("mfhi_stall", stall, 1'b0);
        check("mfhi_rd", rd_data, 32'h1234);
        @(posedge clk); #1;
        op_code = OP_MTLO; rs_data = 32'hABCD;
        @(negedge clk);
        check("mtlo_hi_kept", hi_out, 32'h1234);
        @(posedge clk); #1;
        op_code = OP_MFLO; rs_data = 32'h0;
        @(negedge clk);
        check("mflo_rd", rd_data, 32'hABCD);

        div_busy_len = 4;
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        n = 0; bad = 1'b0;
        while (stall && n < 200) begin
            if (rd_data != 32'h0) bad = 1'b1;
            n++;
            @(posedge clk); #1;
            op_code = OP_MFLO; rs_data = 32'h0; rt_data = 32'h0;
            @(negedge clk);
        end
        check("mflo_held_stall_cycles", n, 7);
        check("mflo_held_rd_zero", bad, 1'b0);
        check("mflo_wb_not_accepted", rd_data, 32'h0);
        check("mflo_wb_lo_old", lo_out, 32'hABCD);
        @(posedge clk); #1;
        @(negedge clk);
        check("mflo_retry_rd", rd_data, 32'd14);
        check("mflo_retry_stall", stall, 1'b0);
        check("divu_hi", hi_out, 32'd2);
        @(posedge clk); #1;
        op_valid = 1'b0;

        div_stuck = 1'b1;
        run_long("div_timeout", OP_DIV, 32'd50, 32'd5, 32'd2, 32'd14, 66, -1);
        check("timeout_err", err_timeout, 1'b1);
        div_stuck = 1'b0;
        run_long("multu_after_to", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 3, -1);
        check("timeout_err_sticky", err_timeout, 1'b1);

        div_busy_len = 32;
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = OP_DIV; rs_data = 32'hFFFF_FFEC; rt_data = 32'd3;
        repeat (6) begin
            @(posedge clk); #1;
            op_valid = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_stall", stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_hi", hi_out, 32'h0);
        check("rst_mid_lo", lo_out, 32'h0);
        check("rst_mid_err", err_timeout, 1'b0);
        check("rst_mid_stall_after", stall, 1'b0);

        run_long("multu_ena_gap", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 8, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
